stage_decode_pipe: RTL and testbench

STAGE_DECODE_PIPE -- requirements
Module: stage_decode_pipe

---
 rtl/stage_decode_pipe.sv | 103 ++++++++++
 tb/tb_stage_decode_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_decode_pipe.sv
// Decode stage with D/X pipeline latch: register-read address decode,
// load-use hazard detection with bubble insertion, and a saturating stall counter.
module stage_decode_pipe #(
    parameter int          PC_W     = 32,
    parameter logic [4:0]  RTYPE_OP = 5'b00000,
    parameter logic [4:0]  LW_OP    = 5'b01000,
    parameter logic [4:0]  BEX_OP   = 5'b10110,
    parameter int          CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    // in_valid/in_ready: an F/D instruction moves into D/X on a rising edge
    // where in_valid & in_ready; out_valid/out_ready: D/X contents are taken
    // by X on an edge where out_valid & out_ready, otherwise they are held.
    input  logic             in_valid,
    input  logic [31:0]      in_insn,
    input  logic [PC_W-1:0]  in_pc,
    output logic             in_ready,
    output logic [4:0]       ctrl_readRegA,
    output logic [4:0]       ctrl_readRegB,
    input  logic             ex_valid,
    input  logic [4:0]       ex_opcode,
    input  logic [4:0]       ex_rd,
    input  logic             flush,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [31:0]      out_insn,
    output logic [PC_W-1:0]  out_pc,
    output logic [CNT_W-1:0] stall_count
);

    logic             r_valid;
    logic [31:0]      r_insn;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [4:0] w_opcode;
    logic [4:0] w_rd;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_a_used;
    logic       w_b_used;
    logic       w_ex_load;
    logic       w_hazard;
    logic       w_hold;

    assign w_opcode = in_insn[31:27];
    assign w_rd     = in_insn[26:22];
    assign w_rs     = in_insn[21:17];
    assign w_rt     = in_insn[16:12];

    assign ctrl_readRegA = (w_opcode == BEX_OP)   ? 5'd30 : w_rs;
    assign ctrl_readRegB = (w_opcode == RTYPE_OP) ? w_rt  : w_rd;

    // Jumps (00001, 00011) read no source; only stores/branches and R-type read port B.
    assign w_a_used = (w_opcode != 5'b00001) && (w_opcode != 5'b00011);
    assign w_b_used = (w_opcode == RTYPE_OP) || (w_opcode == 5'b00010) ||
                      (w_opcode == 5'b00110) || (w_opcode == 5'b00111);

    assign w_ex_load = ex_valid && (ex_opcode == LW_OP) && (ex_rd != 5'd0);
    assign w_hazard  = in_valid && w_ex_load &&
                       ((w_a_used && (ctrl_readRegA == ex_rd)) ||
                        (w_b_used && (ctrl_readRegB == ex_rd)));
    assign w_hold    = r_valid && !out_ready;

    always_comb begin
        in_ready = 1'b1;
        if (flush)         in_ready = 1'b1;
        else if (w_hold)   in_ready = 1'b0;
        else if (w_hazard) in_ready = 1'b0;
    end

    // Priority: flush > downstream hold > hazard bubble > advance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid     <= 1'b0;
            r_insn      <= 32'd0;
            r_pc        <= '0;
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_insn  <= 32'd0;
        end else if (w_hold) begin
            r_valid <= r_valid;
        end else if (w_hazard) begin
            r_valid <= 1'b0;
            r_insn  <= 32'd0;
            if (r_stall_cnt != {CNT_W{1'b1}}) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end else begin
            r_valid <= in_valid;
            r_insn  <= in_insn;
            r_pc    <= in_pc;
        end
    end

    assign out_valid   = r_valid;
    assign out_insn    = r_insn;
    assign out_pc      = r_pc;
    assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_stage_decode_pipe.sv
// Self-checking bench for stage_decode_pipe: directed corner cases plus
// randomized traffic compared against an instruction-level model of the D/X latch.
module tb_stage_decode_pipe;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clock;
    logic             reset_n;
    logic             in_valid;
    logic [31:0]      in_insn;
    logic [PC_W-1:0]  in_pc;
    logic             in_ready;
    logic [4:0]       ctrl_readRegA;
    logic [4:0]       ctrl_readRegB;
    logic             ex_valid;
    logic [4:0]       ex_opcode;
    logic [4:0]       ex_rd;
    logic             flush;
    logic             out_ready;
    logic             out_valid;
    logic [31:0]      out_insn;
    logic [PC_W-1:0]  out_pc;
    logic [CNT_W-1:0] stall_count;

    stage_decode_pipe #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_insn(in_insn), .in_pc(in_pc), .in_ready(in_ready),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
        .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .out_insn(out_insn), .out_pc(out_pc),
        .stall_count(stall_count)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // model of the D/X latch contents
    int          m_valid;
    int          m_zero_insn;
    logic [31:0] m_insn;
    logic [31:0] m_pc;
    int          m_cnt;

    // combinational outputs observed during the last step
    logic [4:0] ls_a, ls_b;
    logic       ls_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt);
        return (op << 27) | (rd << 22) | (rs << 17) | (rt << 12);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_zero_insn = 1; m_insn = 0; m_pc = 0; m_cnt = 0;
    endtask

    task automatic check_regs();
        chk("out_valid", {31'd0, out_valid}, m_valid);
        chk("stall_count", {28'd0, stall_count}, m_cnt);
        if (m_valid != 0) begin
            chk("out_insn", out_insn, m_insn);
            chk("out_pc", out_pc, m_pc);
        end else if (m_zero_insn != 0) begin
            chk("bubble_insn", out_insn, 32'd0);
        end
    endtask

    // Called just after a rising edge: apply inputs, check decode, advance one cycle.
    task automatic step(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                        input logic exv, input int exop, input int exrd,
                        input logic fl, input logic ordy);
        int op, rd, rs, rt, ea, eb, er;
        int a_used, b_used, hz, hold;
        in_valid = v; in_insn = insn; in_pc = pc;
        ex_valid = exv; ex_opcode = exop[4:0]; ex_rd = exrd[4:0];
        flush = fl; out_ready = ordy;
        #1;
        op = insn / (1 << 27);
        rd = (insn / (1 << 22)) % 32;
        rs = (insn / (1 << 17)) % 32;
        rt = (insn / (1 << 12)) % 32;
        ea = (op == 22) ? 30 : rs;
        eb = (op == 0) ? rt : rd;
        a_used = (op != 1 && op != 3);
        b_used = (op == 0 || op == 2 || op == 6 || op == 7);
        hz = v && exv && exop == 8 && exrd != 0 &&
             ((a_used && ea == exrd) || (b_used && eb == exrd));
        hold = m_valid && !ordy;
        er = fl ? 1 : (hold ? 0 : (hz ? 0 : 1));
        ls_a = ctrl_readRegA; ls_b = ctrl_readRegB; ls_rdy = in_ready;
        chk("readRegA", {27'd0, ctrl_readRegA}, ea);
        chk("readRegB", {27'd0, ctrl_readRegB}, eb);
        chk("in_ready", {31'd0, in_ready}, er);
        if (fl) begin
            m_valid = 0; m_zero_insn = 0;
        end else if (hold) begin
            // latch unchanged
        end else if (hz) begin
            m_valid = 0; m_zero_insn = 1; m_insn = 0;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
            m_valid = v; m_zero_insn = 0; m_insn = insn; m_pc = pc;
        end
        @(posedge clock);
        #1;
        check_regs();
    endtask

    task automatic async_reset_pulse();
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_insn", out_insn, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_stall_count", {28'd0, stall_count}, 32'd0);
        #1 reset_n = 1'b1;
    endtask

    logic [31:0] add_i, add2_i, sw_i, bex_i, jmp_i;
    int ops[9] = '{0, 1, 2, 3, 6, 7, 8, 22, 4};

    initial begin
        model_reset();
        reset_n = 1'b0;
        in_valid = 0; in_insn = 0; in_pc = 0;
        ex_valid = 0; ex_opcode = 0; ex_rd = 0; flush = 0; out_ready = 1;
        repeat (2) @(posedge clock);
        #1;
        check_regs();
        reset_n = 1'b1;

        // add r3,r1,r2
        add_i = mk(0, 3, 1, 2);
        step(1, add_i, 32'h100, 0, 0, 0, 0, 1);
        chk("lit_add_a", {27'd0, ls_a}, 32'd1);
        chk("lit_add_b", {27'd0, ls_b}, 32'd2);
        chk("lit_add_valid", {31'd0, out_valid}, 32'd1);
        chk("lit_add_insn", out_insn, 32'h00C2_2000);

        // sw rd=5 rs=6; bex
        sw_i = mk(7, 5, 6, 0);
        step(1, sw_i, 32'h104, 0, 0, 0, 0, 1);
        chk("lit_sw_a", {27'd0, ls_a}, 32'd6);
        chk("lit_sw_b", {27'd0, ls_b}, 32'd5);
        bex_i = mk(22, 0, 9, 0);
        step(1, bex_i, 32'h108, 0, 0, 0, 0, 1);
        chk("lit_bex_a", {27'd0, ls_a}, 32'd30);

        // load-use: X lw r4, D add r7,r4,r1
        add2_i = mk(0, 7, 4, 1);
        step(1, add2_i, 32'h10C, 1, 8, 4, 0, 1);
        chk("lit_hz_rdy", {31'd0, ls_rdy}, 32'd0);
        chk("lit_hz_cnt", {28'd0, stall_count}, 32'd1);
        chk("lit_hz_bubble", {31'd0, out_valid}, 32'd0);
        step(1, add2_i, 32'h10C, 1, 0, 7, 0, 1);
        chk("lit_adv_insn", out_insn, add2_i);

        // lw r0 never stalls
        step(1, mk(0, 7, 0, 0), 32'h110, 1, 8, 0, 0, 1);
        chk("lit_r0_cnt", {28'd0, stall_count}, 32'd1);
        chk("lit_r0_rdy", {31'd0, ls_rdy}, 32'd1);

        // jump ignores port A; in_valid=0 never stalls
        jmp_i = mk(1, 0, 4, 4);
        step(1, jmp_i, 32'h114, 1, 8, 4, 0, 1);
        step(0, add2_i, 32'h118, 1, 8, 4, 0, 1);
        chk("lit_nov_cnt", {28'd0, stall_count}, 32'd1);

        // flush + hazard + out_ready=0 with D/X valid
        step(1, add_i, 32'h11C, 0, 0, 0, 0, 1);
        step(1, add2_i, 32'h120, 1, 8, 4, 1, 0);
        chk("lit_fl_rdy", {31'd0, ls_rdy}, 32'd1);
        chk("lit_fl_valid", {31'd0, out_valid}, 32'd0);
        chk("lit_fl_cnt", {28'd0, stall_count}, 32'd1);

        // saturate the counter
        for (int i = 0; i < CNT_MAX + 4; i++) step(1, add2_i, 32'h124, 1, 8, 4, 0, 1);
        chk("lit_sat", {28'd0, stall_count}, CNT_MAX);

        // reset mid-hold
        step(1, add_i, 32'h128, 0, 0, 0, 0, 1);
        step(1, add2_i, 32'h12C, 0, 0, 0, 0, 0);
        async_reset_pulse();
        step(1, add2_i, 32'h130, 1, 8, 4, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ins;
            ins = mk(ops[$urandom_range(0, 8)], $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 7));
            ins = ins | ($urandom_range(0, 1023) << 2);
            step($urandom_range(0, 3) != 0, ins, $urandom,
                 $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 1) != 0) ? 8 : ops[$urandom_range(0, 8)],
                 $urandom_range(0, 7),
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) async_reset_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
